// File: rtl/fact_pkg.sv
// fact_pkg: shared definitions for the fact peripheral bus interface.
//   - fact_if_state_t : bus-interface FSM states
//   - FACT_ADDR_*     : word addresses (bus addr[3:2]) of the register map
//   - CTRL_* / STAT_* : bit positions inside CTRL and STATUS
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } fact_if_state_t;

  localparam logic [1:0] FACT_ADDR_N      = 2'd0;
  localparam logic [1:0] FACT_ADDR_CTRL   = 2'd1;
  localparam logic [1:0] FACT_ADDR_STATUS = 2'd2;
  localparam logic [1:0] FACT_ADDR_RESULT = 2'd3;

  localparam int CTRL_GO   = 0;
  localparam int CTRL_IE   = 1;
  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

endpackage

// File: rtl/fact_bus_if.sv
// fact_bus_if: memory-mapped register front-end for the fact core.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no run in progress; N_REG writable, CTRL bit0 launches
// LAUNCH | go asserted for this single cycle
// BUSY   | waiting for a rising edge of done or err from the core
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   we, addr, wd  - bus write strobe, word address, write data
//   rd            - bus read data, combinational from addr
//   irq           - level interrupt request (registered)
//   n, go         - operand and start pulse to the core
//   done, err, nf - core completion level, error level, result
module fact_bus_if
  import fact_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             irq,
  output logic [WIDTH-1:0] n,
  output logic             go,
  input  logic             done,
  input  logic             err,
  input  logic [WIDTH-1:0] nf
);

  fact_if_state_t state, state_next;

  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] result;
  logic             ie;
  logic             done_s;
  logic             err_s;
  logic             done_q;
  logic             err_q;

  logic busy;
  logic ctrl_wr;
  logic launch;
  logic done_rise;
  logic err_rise;

  assign busy      = (state != IDLE);
  assign ctrl_wr   = we && (addr == FACT_ADDR_CTRL);
  assign launch    = ctrl_wr && wd[CTRL_GO] && (state == IDLE);
  // Edges are relative to the previous cycle's level, so a level left high
  // from an earlier run never completes a new one.
  assign done_rise = done && !done_q;
  assign err_rise  = err && !err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    unique case (state)
      IDLE:   if (launch) state_next = LAUNCH;
      LAUNCH: begin
        go         = 1'b1;
        state_next = BUSY;
      end
      BUSY:   if (done_rise || err_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg  <= '0;
      result <= '0;
      ie     <= 1'b0;
      done_s <= 1'b0;
      err_s  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      done_q <= done;
      err_q  <= err;
      irq    <= ie && (done_s || err_s);

      if (we && (addr == FACT_ADDR_N) && !busy) n_reg <= wd;

      // IE stays writable during a run so software can mask the interrupt.
      if (ctrl_wr) ie <= wd[CTRL_IE];

      if (launch) begin
        done_s <= 1'b0;
        err_s  <= 1'b0;
      end else if (state == BUSY) begin
        // err has priority when both edges land in the same cycle.
        if (err_rise) begin
          err_s <= 1'b1;
        end else if (done_rise) begin
          done_s <= 1'b1;
          result <= nf;
        end
      end
    end
  end

  assign n = n_reg;

  always_comb begin
    rd = '0;
    unique case (addr)
      FACT_ADDR_N:      rd = n_reg;
      FACT_ADDR_CTRL:   begin
        rd[CTRL_GO] = busy;
        rd[CTRL_IE] = ie;
      end
      FACT_ADDR_STATUS: begin
        rd[STAT_DONE] = done_s;
        rd[STAT_ERR]  = err_s;
      end
      FACT_ADDR_RESULT: rd = result;
      default:          rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_bus_if.sv
// tb_fact_bus_if: directed self-checking bench for fact_bus_if.
// The fact core is played by the bench, which drives done/err/nf directly.
module tb_fact_bus_if;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             irq;
  logic [WIDTH-1:0] n;
  logic             go;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] nf;

  int tests = 0;
  int fails = 0;
  int go_cnt = 0;

  fact_bus_if #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .irq(irq), .n(n), .go(go), .done(done), .err(err), .nf(nf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (go) go_cnt++;

  // Inputs change on falling edges; the rising edge in between samples them.
  task automatic bus_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    we = 1'b0; wd = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [WIDTH-1:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Core signals a rising done edge carrying result r.
  task automatic core_done(input logic [WIDTH-1:0] r);
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    done = 1'b1; nf = r;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] v;
    rst = 1'b1; we = 1'b0; addr = 2'd0; wd = '0; done = 1'b0; err = 1'b0; nf = '0;
    cycles(2);
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], v);
      tests++;
      if (v !== '0) begin fails++; $display("FAIL reset_rd addr=%0d got=%h exp=0", a, v); end
    end
    tests++;
    if (irq !== 1'b0 || go !== 1'b0) begin
      fails++; $display("FAIL reset_irq_go got irq=%b go=%b exp 0 0", irq, go);
    end
    @(negedge clk);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic test_normal_run();
    logic [WIDTH-1:0] v;
    go_cnt = 0;
    bus_write(2'd0, 32'd5);
    bus_write(2'd1, 32'h3);
    tests++;
    if (go !== 1'b1) begin fails++; $display("FAIL normal_go_high got=%b exp=1", go); end
    bus_read(2'd1, v);
    tests++;
    if (v !== 32'h3) begin fails++; $display("FAIL normal_ctrl_busy got=%h exp=3", v); end
    @(negedge clk);
    tests++;
    if (go !== 1'b0) begin fails++; $display("FAIL normal_go_low got=%b exp=0", go); end
    done = 1'b1; nf = 32'd120;
    @(negedge clk);
    bus_read(2'd2, v);
    tests++;
    if (v !== 32'h1) begin fails++; $display("FAIL normal_status got=%h exp=1", v); end
    bus_read(2'd3, v);
    tests++;
    if (v !== 32'd120) begin fails++; $display("FAIL normal_result got=%0d exp=120", v); end
    bus_read(2'd1, v);
    tests++;
    if (v !== 32'h2) begin fails++; $display("FAIL normal_ctrl_idle got=%h exp=2", v); end
    cycles(2);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL normal_irq got=%b exp=1", irq); end
    tests++;
    if (go_cnt != 1) begin fails++; $display("FAIL normal_go_count got=%0d exp=1", go_cnt); end
    done = 1'b0;
  endtask

  task automatic test_error_run();
    logic [WIDTH-1:0] v;
    bus_write(2'd0, 32'd13);
    bus_write(2'd1, 32'h1);
    cycles(2);
    err = 1'b1; nf = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_read(2'd2, v);
    tests++;
    if (v !== 32'h2) begin fails++; $display("FAIL err_status got=%h exp=2", v); end
    bus_read(2'd3, v);
    tests++;
    if (v !== 32'd120) begin fails++; $display("FAIL err_result_kept got=%0d exp=120", v); end
    cycles(2);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL err_irq_masked got=%b exp=0", irq); end
    err = 1'b0;
  endtask

  task automatic test_writes_while_busy();
    logic [WIDTH-1:0] v;
    go_cnt = 0;
    bus_write(2'd0, 32'd6);
    bus_write(2'd1, 32'h3);
    bus_write(2'd0, 32'd9);
    bus_write(2'd1, 32'h1);
    bus_read(2'd0, v);
    tests++;
    if (v !== 32'd6 || n !== 32'd6) begin fails++; $display("FAIL busy_n_kept got rd=%0d n=%0d exp=6", v, n); end
    bus_read(2'd1, v);
    tests++;
    if (v !== 32'h1) begin fails++; $display("FAIL busy_ie_update got=%h exp=1", v); end
    core_done(32'd720);
    bus_read(2'd3, v);
    tests++;
    if (v !== 32'd720) begin fails++; $display("FAIL busy_result got=%0d exp=720", v); end
    cycles(3);
    tests++;
    if (go_cnt != 1) begin fails++; $display("FAIL busy_go_count got=%0d exp=1", go_cnt); end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL busy_irq_masked got=%b exp=0", irq); end
  endtask

  task automatic test_stale_done();
    logic [WIDTH-1:0] v;
    // done is still high from the previous run
    bus_write(2'd0, 32'd4);
    bus_write(2'd1, 32'h3);
    bus_read(2'd2, v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL stale_status_clear got=%h exp=0", v); end
    nf = 32'd999;
    cycles(4);
    bus_read(2'd2, v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL stale_status_hold got=%h exp=0", v); end
    bus_read(2'd1, v);
    tests++;
    if (v !== 32'h3) begin fails++; $display("FAIL stale_still_busy got=%h exp=3", v); end
    core_done(32'd24);
    bus_read(2'd2, v);
    tests++;
    if (v !== 32'h1) begin fails++; $display("FAIL stale_status_done got=%h exp=1", v); end
    bus_read(2'd3, v);
    tests++;
    if (v !== 32'd24) begin fails++; $display("FAIL stale_result got=%0d exp=24", v); end
    cycles(2);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL stale_irq got=%b exp=1", irq); end
  endtask

  task automatic test_ctrl_and_ro_writes();
    logic [WIDTH-1:0] v;
    go_cnt = 0;
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'h0);
    cycles(2);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL ie_clear_irq got=%b exp=0", irq); end
    tests++;
    if (go_cnt != 0) begin fails++; $display("FAIL ctrl_nogo got=%0d exp=0", go_cnt); end
    bus_read(2'd1, v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL ctrl_idle got=%h exp=0", v); end
    bus_read(2'd2, v);
    tests++;
    if (v !== 32'h1) begin fails++; $display("FAIL status_ro got=%h exp=1", v); end
    bus_read(2'd3, v);
    tests++;
    if (v !== 32'd24) begin fails++; $display("FAIL result_ro got=%0d exp=24", v); end
    done = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] v;
    bus_write(2'd0, 32'd7);
    bus_write(2'd1, 32'h3);
    rst = 1'b1;
    #1;
    tests++;
    if (go !== 1'b0) begin fails++; $display("FAIL midrst_go got=%b exp=0", go); end
    bus_read(2'd1, v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL midrst_ctrl got=%h exp=0", v); end
    bus_read(2'd2, v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL midrst_status got=%h exp=0", v); end
    bus_read(2'd3, v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL midrst_result got=%h exp=0", v); end
    bus_read(2'd0, v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL midrst_n got=%h exp=0", v); end
    @(negedge clk);
    rst = 1'b0;
    bus_write(2'd0, 32'd3);
    bus_write(2'd1, 32'h1);
    core_done(32'd6);
    bus_read(2'd3, v);
    tests++;
    if (v !== 32'd6) begin fails++; $display("FAIL midrst_rerun_result got=%0d exp=6", v); end
    bus_read(2'd2, v);
    tests++;
    if (v !== 32'h1) begin fails++; $display("FAIL midrst_rerun_status got=%h exp=1", v); end
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_error_run();
    test_writes_while_busy();
    test_stale_done();
    test_ctrl_and_ro_writes();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
